key_click_decoder: RTL and testbench



---
 rtl/key_click_decoder.sv | 117 +++++++++++
 tb/tb_key_click_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// Groups debounced key presses separated by at most `window` cycles into one
// click event (1, 2 or 3+ presses) and offers it to the consumer over valid/ack.
module key_click_decoder #(
  parameter int bitwidth = 24,
  parameter int window   = 12500000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       key,
  input  logic       ack,
  output logic       evt_valid,
  output logic [1:0] clicks,
  output logic       drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [bitwidth-1:0] TIMER_LAST = bitwidth'(window - 1);

  state_t              r_state;
  logic [bitwidth-1:0] r_timer;
  logic [1:0]          r_cnt;
  logic                r_evt_valid;
  logic [1:0]          r_clicks;
  logic                r_drop;

  state_t              w_state_nxt;
  logic [bitwidth-1:0] w_timer_nxt;
  logic [1:0]          w_cnt_nxt;
  logic                w_evt_valid_nxt;
  logic [1:0]          w_clicks_nxt;
  logic                w_drop_nxt;
  logic                w_press;

  assign w_press = ~key;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_cnt_nxt       = r_cnt;
    w_evt_valid_nxt = r_evt_valid;
    w_clicks_nxt    = r_clicks;
    w_drop_nxt      = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (w_press) begin
          w_state_nxt = COUNT;
          w_cnt_nxt   = 2'd1;
        end
      end

      COUNT: begin
        // A press outranks the timeout landing in the same cycle.
        if (w_press) begin
          w_cnt_nxt   = (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
          w_timer_nxt = '0;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt     = HOLD;
          w_evt_valid_nxt = 1'b1;
          w_clicks_nxt    = r_cnt;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      HOLD: begin
        w_timer_nxt = '0;
        w_drop_nxt  = w_press;
        if (ack) begin
          w_state_nxt     = IDLE;
          w_evt_valid_nxt = 1'b0;
          w_cnt_nxt       = 2'd0;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_timer_nxt     = '0;
        w_cnt_nxt       = 2'd0;
        w_evt_valid_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_cnt       <= 2'd0;
      r_evt_valid <= 1'b0;
      r_clicks    <= 2'd0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_cnt       <= w_cnt_nxt;
      r_evt_valid <= w_evt_valid_nxt;
      r_clicks    <= w_clicks_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  assign evt_valid = r_evt_valid;
  assign clicks    = r_clicks;
  assign drop      = r_drop;

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder: directed scenarios plus random presses/acks,
// compared every cycle against a press-time based event model.
module tb_key_click_decoder;

  localparam int WINDOW = 100;
  localparam int BITW   = 8;

  logic       clk_sys;
  logic       rst_n;
  logic       key;
  logic       ack;
  logic       evt_valid;
  logic [1:0] clicks;
  logic       drop;

  int n_tests;
  int n_fail;

  // Reference model: absolute edge index and time of the latest press.
  int m_n;
  int m_last;
  int m_count;
  int m_clicks;
  bit m_active;
  bit m_pending;
  bit m_drop;

  int valid_hi;
  int drop_hi;

  key_click_decoder #(
    .bitwidth(BITW),
    .window  (WINDOW)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .key      (key),
    .ack      (ack),
    .evt_valid(evt_valid),
    .clicks   (clicks),
    .drop     (drop)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_pending = 1'b0;
    m_drop    = 1'b0;
    m_count   = 0;
    m_clicks  = 0;
    m_last    = 0;
  endtask

  // One sampled rising edge; key is active-low.
  task automatic model_edge(input logic k, input logic a);
    m_n++;
    m_drop = 1'b0;
    if (m_pending) begin
      if (!k) m_drop = 1'b1;
      if (a) m_pending = 1'b0;
    end else if (!k) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_count  = 0;
      end
      m_count++;
      m_last = m_n;
    end else if (m_active && (m_n - m_last) == WINDOW) begin
      m_pending = 1'b1;
      m_active  = 1'b0;
      m_clicks  = (m_count > 3) ? 3 : m_count;
    end
  endtask

  task automatic do_cycle(input logic k, input logic a);
    @(negedge clk_sys);
    key = k;
    ack = a;
    @(posedge clk_sys);
    model_edge(k, a);
    #1;
    check("evt_valid", int'(evt_valid), int'(m_pending));
    check("clicks", int'(clicks), m_clicks);
    check("drop", int'(drop), int'(m_drop));
    if (evt_valid) valid_hi++;
    if (drop) drop_hi++;
  endtask

  task automatic run(input int n, input logic a);
    for (int i = 0; i < n; i++) do_cycle(1'b1, a);
  endtask

  task automatic press(input logic a);
    do_cycle(1'b0, a);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk_sys);
    key = 1'b1;
    ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_valid_async"}, int'(evt_valid), 0);
    check({tag, "_clicks_async"}, int'(clicks), 0);
    check({tag, "_drop_async"}, int'(drop), 0);
    model_reset();
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_n     = 0;
    key     = 1'b1;
    ack     = 1'b0;
    rst_n   = 1'b1;
    model_reset();

    do_reset("init");

    // Single press, ack tied high: valid for exactly one cycle.
    valid_hi = 0;
    drop_hi  = 0;
    run(9, 1'b1);
    press(1'b1);
    run(120, 1'b1);
    check("single_valid_width", valid_hi, 1);
    check("single_clicks", int'(clicks), 1);
    check("single_no_drop", drop_hi, 0);

    // Double click, ack low until the event is pending.
    run(10, 1'b0);
    press(1'b0);
    run(49, 1'b0);
    press(1'b0);
    run(99, 1'b0);
    check("double_not_yet", int'(evt_valid), 0);
    run(1, 1'b0);
    check("double_valid", int'(evt_valid), 1);
    check("double_clicks", int'(clicks), 2);
    run(20, 1'b0);
    do_cycle(1'b1, 1'b1);
    check("double_acked", int'(evt_valid), 0);
    run(3, 1'b0);

    // Boundary gap: a press window-1 cycles later still belongs to the event.
    press(1'b0);
    run(98, 1'b0);
    press(1'b0);
    run(100, 1'b0);
    check("boundary_clicks", int'(clicks), 2);
    do_cycle(1'b1, 1'b1);
    run(90, 1'b0);
    press(1'b0);
    run(100, 1'b0);
    check("boundary_second_clicks", int'(clicks), 1);
    do_cycle(1'b1, 1'b1);

    // Saturation: five presses 20 cycles apart.
    for (int p = 0; p < 5; p++) begin
      press(1'b0);
      run(19, 1'b0);
    end
    run(85, 1'b0);
    check("sat_clicks", int'(clicks), 3);
    check("sat_valid", int'(evt_valid), 1);

    // Pending event: presses dropped, including one coinciding with ack.
    drop_hi = 0;
    run(5, 1'b0);
    press(1'b0);
    run(5, 1'b0);
    press(1'b1);
    run(150, 1'b0);
    check("pending_drops", drop_hi, 2);
    check("pending_no_new_evt", int'(evt_valid), 0);
    press(1'b0);
    run(100, 1'b0);
    check("after_drop_clicks", int'(clicks), 1);
    do_cycle(1'b1, 1'b1);

    // Reset mid-COUNT with cnt=2.
    press(1'b0);
    run(10, 1'b0);
    press(1'b0);
    run(10, 1'b0);
    do_reset("rst_count");
    valid_hi = 0;
    run(200, 1'b0);
    check("rst_count_no_evt", valid_hi, 0);
    press(1'b0);
    run(100, 1'b0);
    check("rst_count_next_clicks", int'(clicks), 1);

    // Reset mid-HOLD.
    do_reset("rst_hold");
    valid_hi = 0;
    run(200, 1'b1);
    check("rst_hold_no_evt", valid_hi, 0);

    // Random presses and acks with occasional reset.
    for (int c = 0; c < 6000; c++) begin
      logic k;
      logic a;
      k = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      a = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 1999) == 0) do_reset("rand_rst");
      else do_cycle(k, a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
